// File: rtl/wb_write_queue.sv
// rtl/wb_write_queue.sv - in-order writeback queue feeding the integer RF write port (optional WB_QUEUE_FWD_EN forwarding)
module wb_write_queue #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DEPTH          = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          lsu_valid,
    output logic                          lsu_ready,
    input  logic [REG_ADDR_WIDTH-1:0]     lsu_rd,
    input  logic [DATA_WIDTH-1:0]         lsu_data,
    input  logic                          exe_valid,
    output logic                          exe_ready,
    input  logic [REG_ADDR_WIDTH-1:0]     exe_rd,
    input  logic [DATA_WIDTH-1:0]         exe_data,
    input  logic                          wp_hold,
    output logic                          rf_wen,
    output logic [REG_ADDR_WIDTH-1:0]     rf_waddr,
    output logic [DATA_WIDTH-1:0]         rf_wdata,
    input  logic [REG_ADDR_WIDTH-1:0]     q_raddr1,
    input  logic [REG_ADDR_WIDTH-1:0]     q_raddr2,
    output logic                          q_pend1,
    output logic                          q_pend2,
    output logic [DATA_WIDTH-1:0]         q_fwd1,
    output logic [DATA_WIDTH-1:0]         q_fwd2,
    output logic [$clog2(DEPTH):0]        q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // queue storage and bookkeeping
    logic [REG_ADDR_WIDTH-1:0] r_rd   [DEPTH];
    logic [DATA_WIDTH-1:0]     r_data [DEPTH];
    logic [PW-1:0]             r_head;
    logic [PW-1:0]             r_tail;
    logic [CW-1:0]             r_count;

    logic                      w_full;
    logic                      w_acc_lsu;
    logic                      w_acc_exe;
    logic                      w_push;
    logic                      w_pop;
    logic [REG_ADDR_WIDTH-1:0] w_push_rd;
    logic [DATA_WIDTH-1:0]     w_push_data;
    logic                      w_pend1;
    logic                      w_pend2;
    logic [DATA_WIDTH-1:0]     w_fwd1;
    logic [DATA_WIDTH-1:0]     w_fwd2;

    // full is judged on the registered count only; a pop in the same cycle does not free a slot early
    assign w_full    = (r_count == CW'(DEPTH));
    assign lsu_ready = !rst && !w_full;
    assign exe_ready = !rst && !w_full && !lsu_valid;
    assign w_acc_lsu = lsu_valid && lsu_ready;
    assign w_acc_exe = exe_valid && exe_ready;

    // LSU wins over EXE: its result belongs to the older instruction
    always_comb begin
        w_push      = 1'b0;
        w_push_rd   = '0;
        w_push_data = '0;
        if (w_acc_lsu) begin
            w_push      = (lsu_rd != '0);
            w_push_rd   = lsu_rd;
            w_push_data = lsu_data;
        end else if (w_acc_exe) begin
            w_push      = (exe_rd != '0);
            w_push_rd   = exe_rd;
            w_push_data = exe_data;
        end
    end

    // x0 writes are swallowed by the handshake and never occupy a slot
    assign w_pop = !rst && (r_count != '0) && !wp_hold;

    // pointer, count and entry update; reset drops every queued entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_rd[r_tail]   <= w_push_rd;
                r_data[r_tail] <= w_push_data;
                r_tail         <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // head entry drives the RF port directly; port is quiet when nothing drains
    assign rf_wen   = w_pop;
    assign rf_waddr = w_pop ? r_rd[r_head]   : '0;
    assign rf_wdata = w_pop ? r_data[r_head] : '0;

    // hazard query: walk occupied slots oldest to youngest so the last match is the youngest value
    always_comb begin : p_query
        logic [PW-1:0] v_idx;
        w_pend1 = 1'b0;
        w_pend2 = 1'b0;
        w_fwd1  = '0;
        w_fwd2  = '0;
        v_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_idx = r_head + PW'(i);
            if (CW'(i) < r_count) begin
                if (r_rd[v_idx] == q_raddr1) begin
                    w_pend1 = 1'b1;
`ifdef WB_QUEUE_FWD_EN
                    w_fwd1  = r_data[v_idx];
`endif
                end
                if (r_rd[v_idx] == q_raddr2) begin
                    w_pend2 = 1'b1;
`ifdef WB_QUEUE_FWD_EN
                    w_fwd2  = r_data[v_idx];
`endif
                end
            end
        end
    end

    assign q_pend1 = !rst && (q_raddr1 != '0) && w_pend1;
    assign q_pend2 = !rst && (q_raddr2 != '0) && w_pend2;
`ifdef WB_QUEUE_FWD_EN
    assign q_fwd1  = q_pend1 ? w_fwd1 : '0;
    assign q_fwd2  = q_pend2 ? w_fwd2 : '0;
`else
    assign q_fwd1  = '0;
    assign q_fwd2  = '0;
`endif
    assign q_count = rst ? '0 : r_count;

endmodule
